// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// Each digit is strobed for SCAN_DIV clocks; display data, decimal points
// and blink mask are captured into shadow registers once per frame so a
// digit never changes mid-scan. Anodes and segments are active-low and
// registered, one cycle behind the digit index.
module seven_seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] disp_num,
    input  logic [7:0]  point_in,
    input  logic [7:0]  blink_in,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done,
    output logic        blink_phase
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          bp_q, bp_d;
    logic [31:0]   sh_num_q, sh_num_d;
    logic [7:0]    sh_pt_q, sh_pt_d;
    logic [7:0]    sh_bl_q, sh_bl_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q, fd_d;

    logic          scan_wrap;
    logic          frame_wrap;
    logic [3:0]    nib;
    logic [6:0]    hex_seg;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign scan_wrap  = (pre_q == SCAN_LAST);
    assign frame_wrap = scan_wrap && (idx_q == 3'd7);
    assign nib        = 4'(sh_num_q >> {idx_q, 2'b00});
    assign hex_seg    = hex_decode(nib);

    // Next-state for scan counters, blink timing, shadow capture and pin drive.
    always_comb begin
        pre_d    = pre_q;
        idx_d    = idx_q;
        fcnt_d   = fcnt_q;
        bp_d     = bp_q;
        sh_num_d = sh_num_q;
        sh_pt_d  = sh_pt_q;
        sh_bl_d  = sh_bl_q;
        an_d     = 8'hFF;
        seg_d    = 8'hFF;
        fd_d     = 1'b0;

        if (!en) begin
            // Disabled: hold everything at the start of a frame and keep the
            // shadows tracking the inputs so enabling shows fresh data at once.
            pre_d    = '0;
            idx_d    = 3'd0;
            fcnt_d   = '0;
            bp_d     = 1'b0;
            sh_num_d = disp_num;
            sh_pt_d  = point_in;
            sh_bl_d  = blink_in;
        end else begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = {~sh_pt_q[idx_q], hex_seg};
            // Blanked digits keep their anode strobe so scan timing is unchanged.
            if (bp_q && sh_bl_q[idx_q]) begin
                seg_d = 8'hFF;
            end

            if (scan_wrap) begin
                pre_d = '0;
                idx_d = idx_q + 3'd1;
            end else begin
                pre_d = pre_q + PW'(1);
            end

            if (frame_wrap) begin
                fd_d     = 1'b1;
                sh_num_d = disp_num;
                sh_pt_d  = point_in;
                sh_bl_d  = blink_in;
                if (fcnt_q == BLINK_LAST) begin
                    fcnt_d = '0;
                    bp_d   = ~bp_q;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            idx_q    <= 3'd0;
            fcnt_q   <= '0;
            bp_q     <= 1'b0;
            sh_num_q <= 32'd0;
            sh_pt_q  <= 8'd0;
            sh_bl_q  <= 8'd0;
            an_q     <= 8'hFF;
            seg_q    <= 8'hFF;
            fd_q     <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            fcnt_q   <= fcnt_d;
            bp_q     <= bp_d;
            sh_num_q <= sh_num_d;
            sh_pt_q  <= sh_pt_d;
            sh_bl_q  <= sh_bl_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_done  = fd_q;
    assign blink_phase = bp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with SCAN_DIV=4, BLINK_DIV=2.
// Expected segment bytes per frame are hand-decoded constants, digit 0 in
// the low byte.
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] disp_num;
    logic [7:0]  point_in;
    logic [7:0]  blink_in;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;
    logic        blink_phase;

    int checks;
    int errors;

    // 12345678, no points: digits 0..7 show 8,7,6,5,4,3,2,1
    localparam logic [63:0] PAT_1234 = 64'hF9A4B0999282F880;
    // 0000000F with point on digit 7
    localparam logic [63:0] PAT_F_DP = 64'h40C0C0C0C0C0C08E;
    // same, digit 0 blanked
    localparam logic [63:0] PAT_F_BL = 64'h40C0C0C0C0C0C0FF;
    // ABCDEF09 with point on digit 0
    localparam logic [63:0] PAT_ABCD = 64'h8883C6A1868EC010;
    // cleared shadow after reset
    localparam logic [63:0] PAT_ZERO = 64'hC0C0C0C0C0C0C0C0;

    seven_seg_scan_ctrl #(
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .disp_num    (disp_num),
        .point_in    (point_in),
        .blink_in    (blink_in),
        .an          (an),
        .seg         (seg),
        .frame_done  (frame_done),
        .blink_phase (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_blank(input string tag);
        check8({tag, "_an"}, an, 8'hFF);
        check8({tag, "_seg"}, seg, 8'hFF);
        check1({tag, "_fd"}, frame_done, 1'b0);
        check1({tag, "_bp"}, blink_phase, 1'b0);
    endtask

    // Step through digits d_from..d_to, four clocks each, checking every cycle.
    task automatic run_digits(input string tag, input logic [63:0] exp_s,
                              input logic bp_in, input logic bp_end,
                              input int d_from, input int d_to);
        logic [7:0] exp_an;
        logic       last;
        for (int d = d_from; d <= d_to; d++) begin
            exp_an = ~(8'd1 << d);
            for (int c = 0; c < 4; c++) begin
                tick();
                last = (d == 7) && (c == 3);
                check8({tag, "_an"}, an, exp_an);
                check8({tag, "_seg"}, seg, exp_s[8*d +: 8]);
                check1({tag, "_fd"}, frame_done, last);
                check1({tag, "_bp"}, blink_phase, last ? bp_end : bp_in);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        disp_num = 32'd0;
        point_in = 8'd0;
        blink_in = 8'd0;

        // Reset state
        tick();
        tick();
        check_blank("reset");
        rst = 1'b0;

        // Disabled for two cycles while inputs are presented
        disp_num = 32'h12345678;
        tick();
        check_blank("dis0");
        tick();
        check_blank("dis1");
        en = 1'b1;

        // Frame 1: 1234 pattern, frame_done at cycle 32
        run_digits("f1", PAT_1234, 1'b0, 1'b0, 0, 7);

        // Frame 2: inputs change at digit 3 but stay invisible; blink toggles at end
        run_digits("f2a", PAT_1234, 1'b0, 1'b0, 0, 2);
        disp_num = 32'h0000000F;
        point_in = 8'h80;
        run_digits("f2b", PAT_1234, 1'b0, 1'b1, 3, 7);

        // Frame 3: new data and point; blink mask set now is not yet captured
        blink_in = 8'h01;
        run_digits("f3", PAT_F_DP, 1'b1, 1'b1, 0, 7);

        // Frame 4: digit 0 blanked while phase is 1
        run_digits("f4", PAT_F_BL, 1'b1, 1'b0, 0, 7);

        // Frames 5 and 6: phase 0, digit 0 visible
        run_digits("f5", PAT_F_DP, 1'b0, 1'b0, 0, 7);
        run_digits("f6", PAT_F_DP, 1'b0, 1'b1, 0, 7);

        // Frame 7: blanked again, enable dropped while digit 5 is lit
        run_digits("f7", PAT_F_BL, 1'b1, 1'b1, 0, 4);
        tick();
        check8("f7_d5a_an", an, 8'hDF);
        check8("f7_d5a_seg", seg, 8'hC0);
        tick();
        check8("f7_d5b_an", an, 8'hDF);
        check8("f7_d5b_seg", seg, 8'hC0);
        en = 1'b0;
        tick();
        check_blank("endrop0");
        disp_num = 32'hABCDEF09;
        point_in = 8'h01;
        blink_in = 8'h00;
        tick();
        check_blank("endrop1");
        en = 1'b1;

        // Frame 8: restarts at digit 0 with freshly loaded data
        run_digits("f8", PAT_ABCD, 1'b0, 1'b0, 0, 7);
        // Frame 9: ends with frame_done and phase both high
        run_digits("f9", PAT_ABCD, 1'b0, 1'b1, 0, 7);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check_blank("async_rst");
        #2;
        rst = 1'b0;

        // After reset: scan from digit 0 with cleared shadow
        run_digits("post_rst", PAT_ZERO, 1'b0, 1'b0, 0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit common-anode seven-segment display.
- Consumes the selected display word, decimal-point mask and blink mask from the display I/O mux.
- Sequences digit strobes at a programmable rate, decodes hex nibbles to segments, and applies blink gating and decimal points.
- Latches display data once per frame so digits never tear mid-scan. Drives the board anode and segment pins directly.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is lit; legal range 1..2^20.
- BLINK_DIV, 64, full frames per blink half-period; legal range 1..2^10.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  display enable
- disp_num  in  32  hex value; digit i shows disp_num[4i+3:4i]
- point_in  in  8  bit i=1 lights the decimal point of digit i
- blink_in  in  8  bit i=1 makes digit i blink
- an  out  8  anode strobes, active-low
- seg  out  8  segments, active-low; seg[7]=dp, seg[6:0]={g,f,e,d,c,b,a}
- frame_done  out  1  one-cycle pulse at frame wrap
- blink_phase  out  1  current blink phase; 1 = blinking digits blanked

Behaviour:
- Reset (async, immediate): an=8'hFF, seg=8'hFF, frame_done=0, blink_phase=0, prescaler=0, digit index idx=0, frame counter=0, shadow data/point/blink=0.
- Prescaler counts 0..SCAN_DIV-1. On a cycle with prescaler==SCAN_DIV-1: prescaler<=0, idx<=idx+1 mod 8. With SCAN_DIV=1 this occurs every cycle.
- Frame wrap is the prescaler wrap while idx==7. In that same edge:
  - frame_done<=1 for exactly one cycle;
  - shadow regs load disp_num, point_in, blink_in;
  - frame counter increments.
- Frame counter at BLINK_DIV-1 on a frame wrap: counter<=0 and blink_phase toggles.
- Output registers update every cycle from current idx and shadow (1-cycle latency from idx change):
  - an <= ~(8'b1 << idx);
  - seg[7] <= ~shadow_point[idx];
  - seg[6:0] <= hex decode of shadow nibble idx;
  - if blink_phase==1 and shadow_blink[idx]==1, seg <= 8'hFF. Anode is still strobed.
- Hex decode for seg[6:0], nibbles 0..F in order: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- en==0 (synchronous):
  - prescaler, idx, frame counter and blink_phase are forced to 0;
  - shadow loads all three inputs every cycle;
  - an<=8'hFF, seg<=8'hFF, frame_done<=0.
  - First cycle with en==1 starts digit 0 with freshly loaded data.
- Input changes between frame wraps while en==1 are invisible until the next frame_done.
- Reset asserted mid-frame: outputs blank immediately. After release, scanning restarts at digit 0 with shadow=0 until the first frame wrap, or until en is low for at least one cycle.
- frame_done and blink update on the same edge; no other simultaneous-event precedence exists.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
1. rst pulse mid-run -> an=FF, seg=FF, frame_done=0, blink_phase=0 asynchronously, before the next clk edge.
2. en=0 two cycles with disp_num=32'h12345678, point_in=0, blink_in=0, then en=1:
   - an=FE for 4 cycles with seg=80, then FD with seg=F8, FB with seg=82, F7 with seg=92;
   - ... F7 shown as an=7F with seg=F9;
   - frame_done pulses once after 32 cycles.
3. Change disp_num to 32'h0000000F while digit 3 is lit -> remaining digits of the current frame still show 1234 pattern; next frame digit0 seg=8E, digits1-7 seg=C0.
4. point_in=8'h80 loaded -> digit7 seg[7]=0; all other digits seg[7]=1.
5. blink_in=8'h01 -> blink_phase toggles every 2 frames (64 cycles). Digit0 seg=FF while phase=1; digit1 unaffected; an still steps FE..7F.
6. en dropped during digit 5 -> an=FF, seg=FF next cycle, idx=0. Re-raising en restarts at an=FE with current inputs.
